avalon_mm_ram_agent: RTL

//  Avalon-MM agent (responder) side of AvalonMmRw: word-addressed on-chip RAM with byte-lane writes,

---
 rtl/avalon_mm_ram_agent.sv | 95 +++++++++
 1 files changed

// File: rtl/avalon_mm_ram_agent.sv
// Avalon-MM responder: word-addressed RAM with byte-lane writes, programmable
// wait states and a fixed-latency pipelined read response.
module avalon_mm_ram_agent #(
  parameter int          DEPTH_WORDS  = 1024,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          WAIT_STATES  = 0,
  parameter int          READ_LATENCY = 2,
  parameter logic [31:0] MISS_DATA    = 32'hDEAD_BEEF
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_address,
  input  logic [3:0]  i_byteenable,
  input  logic        i_read,
  input  logic        i_write,
  input  logic [31:0] i_host_to_agent,
  output logic [31:0] o_agent_to_host,
  output logic        o_waitrequest,
  output logic        o_readdatavalid
);

  localparam int         DATA_W = 32;
  localparam int         AW     = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS     = 4'(WAIT_STATES);

  logic              w_cmd;
  logic              w_accept;
  logic              w_rd_accept;
  logic              w_wr_accept;
  logic              w_hit;
  logic [AW-1:0]     w_index;
  logic [1:0]        w_unused_addr;

  logic [3:0]        r_wcnt;
  logic [DATA_W-1:0] r_ram [DEPTH_WORDS];
  logic [READ_LATENCY-1:0] r_vld_p;
  logic [DATA_W-1:0] r_data_p [READ_LATENCY];

  assign w_unused_addr = i_address[1:0];
  assign w_hit         = (i_address[31:2+AW] == BASE_ADDR[31:2+AW]);
  assign w_index       = i_address[2+AW-1:2];

  // Write wins when read and write are asserted together.
  assign w_cmd         = i_read | i_write;
  assign o_waitrequest = i_reset | (w_cmd & (r_wcnt != WS));
  assign w_accept      = w_cmd & ~o_waitrequest;
  assign w_wr_accept   = w_accept & i_write;
  assign w_rd_accept   = w_accept & i_read & ~i_write;

  // Counter also clears when the host drops the command so it cannot wedge.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wcnt <= '0;
    end else if (!w_cmd || w_accept) begin
      r_wcnt <= '0;
    end else begin
      r_wcnt <= r_wcnt + 4'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr_accept && w_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (i_byteenable[b]) begin
          r_ram[w_index][8*b +: 8] <= i_host_to_agent[8*b +: 8];
        end
      end
    end
  end

  // Stage p0: RAM sampled at the accept edge; later stages just shift.
  always_ff @(posedge i_clk) begin
    if (w_rd_accept) begin
      r_data_p[0] <= w_hit ? r_ram[w_index] : MISS_DATA;
    end
    for (int k = 1; k < READ_LATENCY; k++) begin
      r_data_p[k] <= r_data_p[k-1];
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_vld_p <= '0;
    end else begin
      r_vld_p[0] <= w_rd_accept;
      for (int k = 1; k < READ_LATENCY; k++) begin
        r_vld_p[k] <= r_vld_p[k-1];
      end
    end
  end

  assign o_readdatavalid = r_vld_p[READ_LATENCY-1];
  assign o_agent_to_host = o_readdatavalid ? r_data_p[READ_LATENCY-1] : '0;

endmodule
